// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, FSM encoding and saturating clamp for the voice engine
package audio_pkg;
    localparam logic [1:0] WAVE_SAW = 2'd0, WAVE_SQUARE = 2'd1, WAVE_TRI = 2'd2, WAVE_OFF = 2'd3;
    localparam logic [1:0] REG_INC = 2'd0, REG_WAVE = 2'd1, REG_ATK = 2'd2, REG_REL = 2'd3;
    typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] a, input int unsigned bd);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (bd - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bd - 1));
        return a > hi ? hi : a < lo ? lo : a;
    endfunction
endpackage

// File: rtl/voice_wave.sv
// voice_wave: shapes a phase top slice into a signed, midpoint-centred waveform sample
module voice_wave import audio_pkg::*; #(
    parameter int BITDEPTH = 14
) (
    input  logic [BITDEPTH-1:0]        top,
    input  logic [1:0]                 wave,
    output logic signed [BITDEPTH:0]   sample
);
    logic [BITDEPTH-1:0] dbl, shaped;
    always_comb begin
        dbl = top << 1;
        shaped = wave == WAVE_SAW ? top : wave == WAVE_SQUARE ? {BITDEPTH{top[BITDEPTH-1]}} : top[BITDEPTH-1] ? ~dbl : dbl;
        sample = wave == WAVE_OFF ? '0 : $signed({1'b0, shaped}) - $signed({2'b01, {(BITDEPTH-1){1'b0}}});
    end
endmodule

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: time-multiplexed N-voice oscillator/envelope mixer producing one unsigned sample per frame
module poly_voice_engine import audio_pkg::*; #(
    parameter int NVOICES     = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6,
    parameter int VOLBITS     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_clock,
    input  logic                       wr_en,
    input  logic [$clog2(NVOICES)-1:0] wr_voice,
    input  logic [1:0]                 wr_addr,
    input  logic [15:0]                wr_data,
    input  logic [NVOICES-1:0]         gate,
    output logic [BITDEPTH-1:0]        mix,
    output logic                       mix_valid,
    output logic                       busy
);
    localparam int PHASEW = BITDEPTH + BITFRACTION;
    localparam int VW = $clog2(NVOICES);
    localparam int AW = BITDEPTH + VW + 1;
    localparam int PW = BITDEPTH + VOLBITS + 2;
    localparam logic [BITDEPTH-1:0] MID = BITDEPTH'(1) << (BITDEPTH - 1);

    logic [PHASEW-1:0]  phase [NVOICES];
    logic [15:0]        inc   [NVOICES];
    logic [1:0]         wave  [NVOICES];
    logic [VOLBITS-1:0] atk   [NVOICES];
    logic [VOLBITS-1:0] rel   [NVOICES];
    logic [VOLBITS-1:0] env   [NVOICES];

    state_t                  state;
    logic [VW-1:0]           v;
    logic                    sc_q;
    logic signed [AW-1:0]    acc;
    logic [PHASEW-1:0]       nphase;
    logic [VOLBITS:0]        up, dn;
    logic [VOLBITS-1:0]      nenv;
    logic signed [BITDEPTH:0] w;
    logic signed [PW-1:0]    prod;
    logic signed [31:0]      sat;

    voice_wave #(.BITDEPTH(BITDEPTH)) u_wave (
        .top(nphase[PHASEW-1 -: BITDEPTH]),
        .wave(wave[v]),
        .sample(w)
    );

    always_comb begin
        nphase = phase[v] + PHASEW'(inc[v]);
        up = {1'b0, env[v]} + {1'b0, atk[v]};
        dn = {1'b0, env[v]} - {1'b0, rel[v]};
        nenv = gate[v] ? (up[VOLBITS] ? '1 : up[VOLBITS-1:0]) : (dn[VOLBITS] ? '0 : dn[VOLBITS-1:0]);
        prod = PW'(w) * PW'($signed({1'b0, nenv}));
        sat = sat_clamp(32'(acc), BITDEPTH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NVOICES; i++) begin
                phase[i] <= '0;
                inc[i] <= '0;
                wave[i] <= '0;
                atk[i] <= '0;
                rel[i] <= '0;
                env[i] <= '0;
            end
            state <= IDLE;
            v <= '0;
            sc_q <= 1'b0;
            acc <= '0;
            mix <= MID;
            mix_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            sc_q <= sample_clock;
            mix_valid <= 1'b0;
            if (wr_en) begin
                if (wr_addr == REG_INC) inc[wr_voice] <= wr_data;
                if (wr_addr == REG_WAVE) wave[wr_voice] <= wr_data[1:0];
                if (wr_addr == REG_ATK) atk[wr_voice] <= wr_data[VOLBITS-1:0];
                if (wr_addr == REG_REL) rel[wr_voice] <= wr_data[VOLBITS-1:0];
            end
            case (state)
                IDLE: if (sample_clock && !sc_q) begin
                    state <= RUN;
                    busy <= 1'b1;
                    acc <= '0;
                    v <= '0;
                end
                RUN: begin
                    phase[v] <= nphase;
                    env[v] <= nenv;
                    acc <= acc + AW'(prod >>> VOLBITS);
                    v <= v + 1'b1;
                    if (&v) state <= SAT;
                end
                SAT: begin
                    mix <= BITDEPTH'(sat + (32'sd1 <<< (BITDEPTH - 1)));
                    mix_valid <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_voice_engine.sv
// tb_poly_voice_engine: directed and randomized frames checked against an arithmetic voice model
module tb_poly_voice_engine;
    logic        clk = 0, rst = 0, sample_clock = 0, wr_en = 0;
    logic [1:0]  wr_voice = 0, wr_addr = 0;
    logic [15:0] wr_data = 0;
    logic [3:0]  gate = 0;
    logic [13:0] mix;
    logic        mix_valid, busy;
    int errors = 0, checks = 0;
    int m_phase[4], m_env[4], m_inc[4], m_wave[4], m_atk[4], m_rel[4];

    poly_voice_engine dut (
        .clk(clk), .rst(rst), .sample_clock(sample_clock), .wr_en(wr_en),
        .wr_voice(wr_voice), .wr_addr(wr_addr), .wr_data(wr_data), .gate(gate),
        .mix(mix), .mix_valid(mix_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void mreset;
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0; m_env[i] = 0; m_inc[i] = 0; m_wave[i] = 0; m_atk[i] = 0; m_rel[i] = 0;
        end
    endfunction

    function automatic void mwrite(input int vv, input int a, input int d);
        if (a == 0) m_inc[vv] = d & 16'hffff;
        if (a == 1) m_wave[vv] = d & 3;
        if (a == 2) m_atk[vv] = d & 255;
        if (a == 3) m_rel[vv] = d & 255;
    endfunction

    function automatic int model_frame(input logic [3:0] g);
        int acc, top, w;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = (m_phase[i] + m_inc[i]) % (1 << 20);
            top = m_phase[i] / 64;
            if (m_wave[i] == 0) w = top;
            else if (m_wave[i] == 1) w = top >= 8192 ? 16383 : 0;
            else w = top >= 8192 ? 32767 - 2 * top : 2 * top;
            m_env[i] = g[i] ? (m_env[i] + m_atk[i] > 255 ? 255 : m_env[i] + m_atk[i])
                            : (m_env[i] - m_rel[i] < 0 ? 0 : m_env[i] - m_rel[i]);
            if (m_wave[i] != 3) acc += ((w - 8192) * m_env[i]) >>> 8;
        end
        if (acc > 8191) acc = 8191;
        if (acc < -8192) acc = -8192;
        return acc + 8192;
    endfunction

    task automatic wr(input int vv, input int a, input int d);
        wr_en = 1; wr_voice = 2'(vv); wr_addr = 2'(a); wr_data = 16'(d);
        tick;
        wr_en = 0;
        mwrite(vv, a, d);
    endtask

    task automatic do_reset;
        rst = 0;
        tick;
        tick;
        rst = 1;
        mreset();
    endtask

    task automatic run_frame(input logic [3:0] g, input bit dbl, input bit mw, input int ma, input int md, output int m);
        int exp;
        logic [7:0] bp, vp;
        gate = g;
        exp = model_frame(g);
        sample_clock = 1; bp = 0; vp = 0; m = -1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            bp[i-1] = busy;
            vp[i-1] = mix_valid;
            if (mix_valid) m = int'(mix);
            if (i == 1) begin
                sample_clock = 0;
                if (mw) begin wr_en = 1; wr_voice = 0; wr_addr = 2'(ma); wr_data = 16'(md); end
            end
            if (i == 2) wr_en = 0;
            if (i == 3 && dbl) sample_clock = 1;
            if (i == 4) sample_clock = 0;
        end
        if (mw) mwrite(0, ma, md);
        chk("busy_pattern", bp, 8'h1f);
        chk("valid_pattern", vp, 8'h20);
        chk("mix_model", m, exp);
    endtask

    initial begin
        int m, cnt;
        mreset();
        tick; tick;
        rst = 1;
        chk("reset_mix", mix, 8192);
        chk("reset_valid", mix_valid, 0);
        chk("reset_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick; cnt += int'(mix_valid) + int'(busy); end
        chk("idle_no_activity", cnt, 0);

        wr(0, 0, 16384); wr(0, 1, 0); wr(0, 2, 255);
        for (int i = 1; i < 4; i++) wr(i, 1, 3);
        for (int k = 1; k <= 70; k++) begin
            run_frame(4'b0001, k == 1, 0, 0, 0, m);
            if (k == 1) chk("saw_frame1", m, 287);
            if (k == 63) chk("saw_top16128", m, 16097);
            if (k == 64) chk("saw_wrap0", m, 32);
        end

        do_reset();
        wr(0, 1, 1); wr(0, 2, 16);
        for (int i = 1; i < 4; i++) wr(i, 1, 3);
        for (int k = 1; k <= 17; k++) begin
            run_frame(4'b0001, 0, 0, 0, 0, m);
            chk("env_attack", m, 8192 - 32 * (16 * k > 255 ? 255 : 16 * k));
        end
        wr(0, 3, 100);
        for (int k = 1; k <= 4; k++) begin
            run_frame(4'b0000, 0, 0, 0, 0, m);
            chk("env_release", m, 8192 - 32 * (255 - 100 * k < 0 ? 0 : 255 - 100 * k));
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin wr(i, 1, 1); wr(i, 0, 65535); wr(i, 2, 255); end
        for (int k = 0; k < 9; k++) run_frame(4'b0000, 0, 0, 0, 0, m);
        for (int i = 0; i < 4; i++) wr(i, 0, 0);
        run_frame(4'b1111, 0, 0, 0, 0, m);
        chk("sat_high", m, 16383);
        do_reset();
        for (int i = 0; i < 4; i++) begin wr(i, 1, 1); wr(i, 2, 255); end
        run_frame(4'b1111, 0, 0, 0, 0, m);
        chk("sat_low", m, 0);

        do_reset();
        wr(0, 0, 16384); wr(0, 2, 255);
        for (int i = 1; i < 4; i++) wr(i, 1, 3);
        gate = 4'b0001;
        sample_clock = 1;
        tick;
        sample_clock = 0;
        tick; tick;
        #2 rst = 0;
        #1;
        chk("abort_mix", mix, 8192);
        chk("abort_valid", mix_valid, 0);
        chk("abort_busy", busy, 0);
        tick;
        rst = 1;
        mreset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin tick; cnt += int'(mix_valid); end
        chk("abort_no_pulse", cnt, 0);
        wr(0, 0, 16384); wr(0, 2, 255);
        for (int i = 1; i < 4; i++) wr(i, 1, 3);
        run_frame(4'b0001, 0, 0, 0, 0, m);
        chk("abort_fresh_frame", m, 287);

        do_reset();
        for (int i = 0; i < 4; i++)
            for (int a = 0; a < 4; a++) wr(i, a, int'($urandom_range(0, 65535)));
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
            run_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
